dct_2d_8x8_seq: RTL and testbench

//   Sequencer that runs a full 8x8 2D DCT on one shared dct_1d_8x8 instance. It has two passes.
//   Row pass: it accepts one Q16.16 block over a valid/ready handshake and drives it to the 1D core.

---
 rtl/dct_2d_8x8_seq.sv | 149 ++++++++++++++
 tb/tb_dct_2d_8x8_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_2d_8x8_seq.sv
// dct_2d_8x8_seq
//   Drives a full 8x8 2D DCT through one shared dct_1d_8x8 core in two passes.
//   Row pass: an accepted Q16.16 block goes straight to the core.
//   Column pass: the row result is transposed and driven back to the core.
//   The column result is transposed back into row-major order and held for the consumer.
//   Only one block is in flight at a time. The sequencer does no arithmetic; it only moves elements.
//
// Ports
//   clk          rising-edge system clock
//   reset_n      asynchronous active-low reset
//   in_valid     in_data holds a block
//   in_ready     sequencer can accept a block (state IDLE)
//   in_data      spatial block, row-major, element (r,c) at [(r*8+c)*DATA_WIDTH +: DATA_WIDTH]
//   dct_data_in  registered operand for dct_1d_8x8.data_in
//   dct_out      result from dct_1d_8x8.dct_out, valid DCT_LATENCY edges after dct_data_in changes
//   pass_col     0 = row pass, 1 = column pass (probe)
//   out_valid    out_data holds a finished 2D block
//   out_ready    consumer accepts out_data
//   out_data     registered 2D DCT block, row-major
//   block_cnt    completed output handshakes, wraps silently
module dct_2d_8x8_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int DCT_LATENCY = 2,
  localparam int TOTAL_BITS = DATA_WIDTH * 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] in_data,
  output logic [TOTAL_BITS-1:0] dct_data_in,
  input  logic [TOTAL_BITS-1:0] dct_out,
  output logic                  pass_col,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] out_data,
  output logic [15:0]           block_cnt
);

  localparam int CNT_W = (DCT_LATENCY < 1) ? 1 : $clog2(DCT_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(DCT_LATENCY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             lat_hit;

  // Element (r,c) of the result is element (c,r) of x.
  function automatic logic [TOTAL_BITS-1:0] transpose(input logic [TOTAL_BITS-1:0] x);
    logic [TOTAL_BITS-1:0]  t;
    logic signed [DATA_WIDTH-1:0] elem;
    t = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        elem = x[(c*8+r)*DATA_WIDTH +: DATA_WIDTH];
        t[(r*8+c)*DATA_WIDTH +: DATA_WIDTH] = elem;
      end
    end
    return t;
  endfunction

  assign lat_hit = (cnt == LAT);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    pass_col   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ROW;
      end
      ROW: begin
        if (lat_hit) state_next = COL;
      end
      COL: begin
        pass_col = 1'b1;
        if (lat_hit) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Core operand, wait counter, result capture and handshake bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_data_in <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      cnt         <= '0;
      block_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dct_data_in <= in_data;
            cnt         <= ONE;
          end
        end
        ROW: begin
          if (lat_hit) begin
            dct_data_in <= transpose(dct_out);
            cnt         <= ONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        COL: begin
          // dct_data_in is left alone so the core input stays stable through DONE.
          if (lat_hit) begin
            out_data  <= transpose(dct_out);
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            block_cnt <= block_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_2d_8x8_seq.sv
// tb_dct_2d_8x8_seq
//   Bench for dct_2d_8x8_seq with DCT_LATENCY=2. The 1D core is modelled here:
//   either a pass-through stub or an orthonormal 8-point row DCT in real arithmetic.
//   The dct_data_in register inside the sequencer provides the first of the two
//   latency edges, the model register below provides the second.
module tb_dct_2d_8x8_seq;

  localparam int DW = 32;
  localparam int TB = DW * 64;
  localparam real PI = 3.14159265358979323846;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [TB-1:0] in_data;
  logic [TB-1:0] dct_data_in;
  logic [TB-1:0] dct_out;
  logic          pass_col;
  logic          out_valid;
  logic          out_ready;
  logic [TB-1:0] out_data;
  logic [15:0]   block_cnt;

  logic          use_real;
  logic [TB-1:0] core_q;

  int n_checks;
  int n_fail;

  dct_2d_8x8_seq #(
    .DATA_WIDTH (DW),
    .DCT_LATENCY(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .dct_data_in(dct_data_in),
    .dct_out    (dct_out),
    .pass_col   (pass_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .block_cnt  (block_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Orthonormal 8-point DCT applied to every row of x.
  function automatic logic [TB-1:0] dct_rows(input logic [TB-1:0] x);
    logic [TB-1:0] y;
    real acc;
    real ck;
    real xv;
    int  v;
    y = '0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        acc = 0.0;
        ck  = (k == 0) ? $sqrt(1.0 / 8.0) : $sqrt(2.0 / 8.0);
        for (int n = 0; n < 8; n++) begin
          xv  = $itor($signed(x[(r*8+n)*DW +: DW])) / 65536.0;
          acc = acc + xv * $cos(real'((2*n+1)*k) * PI / 16.0);
        end
        acc = acc * ck * 65536.0;
        v   = $rtoi((acc >= 0.0) ? acc + 0.5 : acc - 0.5);
        y[(r*8+k)*DW +: DW] = v;
      end
    end
    return y;
  endfunction

  always_ff @(posedge clk) begin
    core_q <= use_real ? dct_rows(dct_data_in) : dct_data_in;
  end
  assign dct_out = core_q;

  function automatic logic [TB-1:0] gen_block(input logic [31:0] base, input logic [31:0] step_v);
    logic [TB-1:0] b;
    for (int i = 0; i < 64; i++) b[i*DW +: DW] = base + step_v * 32'(i);
    return b;
  endfunction

  function automatic logic [31:0] el(input logic [TB-1:0] b, input int r, input int c);
    return b[(r*8+c)*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [TB-1:0] act, input logic [TB-1:0] exp);
    int bad;
    bad = -1;
    for (int i = 63; i >= 0; i--) if (act[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: element %0d got 0x%08h expected 0x%08h",
               name, bad, act[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Presents blk for one accept edge; returns 1 ns after that edge (E0).
  task automatic accept_block(input logic [TB-1:0] blk);
    wait_ready();
    in_data  = blk;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] step_v;
    logic [31:0] exp_out_r0c7;
    logic [31:0] exp_col_r0c7;
    logic [31:0] exp_col_r7c0;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [TB-1:0] blk;
    logic [TB-1:0] hold_out;
    logic [TB-1:0] hold_dct;
    logic [TB-1:0] t6_blk[3];
    int            exp_cnt;
    int            e;
    int            worst;
    int            bad;
    int            nacc;
    int            npop;
    int            acc_cyc[3];

    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    use_real = 1'b0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data  = '0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0007, 32'h0000_0038, 32'h0000_0007};
    vecs[1] = '{32'h0001_0000, 32'h0000_0100, 32'h0001_0700, 32'h0001_3800, 32'h0001_0700};
    vecs[2] = '{32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFE_FFF9, 32'hFFFE_FFC8, 32'hFFFE_FFF9};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};

    // Reset state
    step();
    step();
    chk_blk("rst_dct_data_in", dct_data_in, '0);
    chk_blk("rst_out_data", out_data, '0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pass_col", 32'(pass_col), 32'd0);
    chk("rst_block_cnt", 32'(block_cnt), 32'd0);
    reset_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // T1 latency and pass-through over a table of blocks
    for (int v = 0; v < 4; v++) begin
      blk = gen_block(vecs[v].base, vecs[v].step_v);
      wait_ready();
      chk("t1_in_ready_idle", 32'(in_ready), 32'd1);
      in_data  = blk;
      in_valid = 1'b1;
      step();                                   // E0
      in_valid = 1'b0;
      chk("t1_in_ready_e0", 32'(in_ready), 32'd0);
      chk("t1_pass_col_e0", 32'(pass_col), 32'd0);
      step();                                   // E0+1
      chk("t1_pass_col_e1", 32'(pass_col), 32'd0);
      step();                                   // E0+2
      chk("t1_pass_col_e2", 32'(pass_col), 32'd1);
      chk("t1_col_r0c7", el(dct_data_in, 0, 7), vecs[v].exp_col_r0c7);
      chk("t1_col_r7c0", el(dct_data_in, 7, 0), vecs[v].exp_col_r7c0);
      step();                                   // E0+3
      chk("t1_pass_col_e3", 32'(pass_col), 32'd1);
      chk("t1_out_valid_e3", 32'(out_valid), 32'd0);
      step();                                   // E0+4
      chk("t1_out_valid_e4", 32'(out_valid), 32'd1);
      chk("t1_pass_col_e4", 32'(pass_col), 32'd0);
      chk("t1_in_ready_done", 32'(in_ready), 32'd0);
      chk("t1_out_r0c7", el(out_data, 0, 7), vecs[v].exp_out_r0c7);
      chk_blk("t1_out_block", out_data, blk);
      out_ready = 1'b1;
      step();                                   // pop edge
      out_ready = 1'b0;
      exp_cnt++;
      chk("t1_out_valid_pop", 32'(out_valid), 32'd0);
      chk("t1_block_cnt", 32'(block_cnt), 32'(exp_cnt));
      chk("t1_in_ready_pop", 32'(in_ready), 32'd1);
    end

    // T2 DC block through the real core
    use_real = 1'b1;
    accept_block(gen_block(32'h0001_0000, 32'h0));
    wait_out_valid();
    e = $signed(out_data[31:0]);
    chk("t2_dc_in_range", 32'((e >= 32'sh0007_8000) && (e <= 32'sh0008_8000)), 32'd1);
    worst = 0;
    bad = 0;
    for (int i = 1; i < 64; i++) begin
      e = $signed(out_data[i*DW +: DW]);
      if (e < 0) e = -e;
      if (e > worst) worst = e;
    end
    chk("t2_ac_max_abs_ok", 32'(worst <= 32'h8000), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt++;
    use_real = 1'b0;

    // T3 single off-diagonal element
    blk = '0;
    blk[1*DW +: DW] = 32'h11;
    accept_block(blk);
    step();
    step();                                     // E0+2, column pass
    chk("t3_pass_col", 32'(pass_col), 32'd1);
    chk("t3_col_r1c0", el(dct_data_in, 1, 0), 32'h11);
    chk("t3_col_r0c1", el(dct_data_in, 0, 1), 32'h0);
    wait_out_valid();
    chk_blk("t3_out_block", out_data, blk);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt++;

    // T4 backpressure, with a competing block offered on in_data
    blk = gen_block(32'h0000_1234, 32'h3);
    accept_block(blk);
    wait_out_valid();
    hold_out = out_data;
    hold_dct = dct_data_in;
    in_data  = gen_block(32'hDEAD_0000, 32'h5);
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_data !== hold_out || dct_data_in !== hold_dct) bad |= 1;
      if (in_ready !== 1'b0) bad |= 2;
      if (block_cnt !== 16'(exp_cnt)) bad |= 4;
      if (out_valid !== 1'b1) bad |= 8;
    end
    chk("t4_data_stable", 32'(bad & 1), 32'd0);
    chk("t4_in_ready_low", 32'(bad & 2), 32'd0);
    chk("t4_block_cnt_held", 32'(bad & 4), 32'd0);
    chk("t4_out_valid_held", 32'(bad & 8), 32'd0);
    chk_blk("t4_out_block", out_data, blk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt++;
    chk("t4_block_cnt_inc", 32'(block_cnt), 32'(exp_cnt));
    chk("t4_in_ready_after", 32'(in_ready), 32'd1);
    chk("t4_out_valid_after", 32'(out_valid), 32'd0);

    // T5 reset in the middle of the column pass
    accept_block(gen_block(32'h0000_0100, 32'h1));
    step();
    step();
    chk("t5_in_col", 32'(pass_col), 32'd1);
    chk("t5_cnt_nonzero", 32'(block_cnt), 32'(exp_cnt));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_pass_col", 32'(pass_col), 32'd0);
    chk_blk("t5_dct_data_in", dct_data_in, '0);
    chk("t5_block_cnt", 32'(block_cnt), 32'd0);
    exp_cnt = 0;
    step();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid !== 1'b0) bad |= 1;
      if (in_ready !== 1'b1) bad |= 2;
    end
    chk("t5_no_stale_output", 32'(bad & 1), 32'd0);
    chk("t5_in_ready_after", 32'(bad & 2), 32'd0);
    chk_blk("t5_out_data_clear", out_data, '0);

    // T6 three back-to-back blocks, in_valid and out_ready held high
    t6_blk[0] = gen_block(32'h0000_1000, 32'h1);
    t6_blk[1] = gen_block(32'h0000_2000, 32'h2);
    t6_blk[2] = gen_block(32'h8000_0000, 32'h10);
    nacc = 0;
    npop = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 60 && npop < 3; cyc++) begin
      if (out_valid) begin
        if (npop < nacc) chk_blk("t6_out_order", out_data, t6_blk[npop]);
        npop++;
      end
      if (nacc == 3) in_valid = 1'b0;
      if (in_ready && nacc < 3) begin
        in_data = t6_blk[nacc];
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      step();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("t6_outputs_seen", 32'(npop), 32'd3);
    chk("t6_accept_gap_01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    chk("t6_accept_gap_12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    chk("t6_block_cnt", 32'(block_cnt), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
